dm_responder: RTL

- Data-memory responder: the slave end of the pipeline's load/store data port.
- Accepts one request at a time over a req/ready handshake and inserts a programmable number of wait states.
- Performs byte/half/word writes and sign- or zero-extended reads from a little-endian byte array.
- Replaces the single-cycle data memory when the pipeline moves to a stall-on-memory model; MEM stage holds req until ready.

---
 rtl/dm_responder_if.sv | 28 ++
 rtl/dm_responder.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/dm_responder_if.sv
// Data-memory port between the pipeline MEM stage (master) and the
// data-memory responder (slave). With DM_ALIGN_ERR_EN defined the bundle
// also carries the misalignment error flag.
interface dm_responder_if #(
    parameter int ADDR_W = 8
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        wtype;
    logic [31:0]       din;
    logic              ready;
    logic [31:0]       dout;
    logic              busy;
`ifdef DM_ALIGN_ERR_EN
    logic              err;

    modport master (output req, we, addr, wtype, din,
                    input  ready, dout, busy, err);
    modport slave  (input  req, we, addr, wtype, din,
                    output ready, dout, busy, err);
`else
    modport master (output req, we, addr, wtype, din,
                    input  ready, dout, busy);
    modport slave  (input  req, we, addr, wtype, din,
                    output ready, dout, busy);
`endif
endinterface

// File: rtl/dm_responder.sv
// Data-memory responder: slave end of the load/store data port.
// Accepts one request at a time, waits WAIT_CYC cycles, then commits a
// store or captures a load (little-endian, sign/zero extended) and pulses
// ready for one cycle.
// Optional feature macro: DM_ALIGN_ERR_EN
//   defined   -> misaligned word/half accesses are suppressed and flagged on err
//   undefined -> low address bits are masked to natural alignment
module dm_responder #(
    parameter int ADDR_W   = 8,
    parameter int WAIT_CYC = 2
) (
    input  logic          clk,
    input  logic          clrn,
    dm_responder_if.slave dm
);
    localparam int         DEPTH   = 1 << ADDR_W;
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        wtype_q;
    logic [31:0]       din_q;
    logic [31:0]       dout_q, dout_d;
    logic              err_q;
    logic [7:0]        mem_q [DEPTH];

    logic              accept, commit;
    logic              op_we;
    logic [ADDR_W-1:0] op_addr, base_addr;
    logic [2:0]        op_wtype;
    logic [31:0]       op_din;
    logic              is_half, is_byte, is_word, is_signed;
    logic              misalign, suppress;
    logic [ADDR_W-1:0] byte_addr [4];
    logic [31:0]       rd_word, load_val;
    logic [3:0]        wr_lane;

    // Next-state logic; commit marks the clock edge that enters RESP
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dm.req) begin
                    accept = 1'b1;
                    cnt_d  = WAIT_LD;
                    if (WAIT_CYC == 0) begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operands: live inputs on a zero-wait commit from IDLE, latched copy otherwise
    always_comb begin
        op_we     = (state_q == S_IDLE) ? dm.we    : we_q;
        op_addr   = (state_q == S_IDLE) ? dm.addr  : addr_q;
        op_wtype  = (state_q == S_IDLE) ? dm.wtype : wtype_q;
        op_din    = (state_q == S_IDLE) ? dm.din   : din_q;
        is_half   = (op_wtype == 3'b001) || (op_wtype == 3'b010);
        is_byte   = (op_wtype == 3'b011) || (op_wtype == 3'b100);
        is_word   = !is_half && !is_byte;
        is_signed = (op_wtype == 3'b001) || (op_wtype == 3'b011);
        misalign  = (is_word && (op_addr[1:0] != 2'b00)) || (is_half && op_addr[0]);
`ifdef DM_ALIGN_ERR_EN
        suppress  = misalign;
        base_addr = op_addr;
`else
        suppress  = 1'b0;
        base_addr = is_word ? (op_addr & ~ADDR_W'(3)) :
                    is_half ? (op_addr & ~ADDR_W'(1)) : op_addr;
`endif
        wr_lane   = {is_word, is_word, !is_byte, 1'b1};
    end

    // Byte lanes: index arithmetic wraps naturally at ADDR_W bits
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign byte_addr[gi]        = base_addr + ADDR_W'(gi);
        assign rd_word[8*gi +: 8]   = mem_q[byte_addr[gi]];
    end

    // Load extension and response data selection
    always_comb begin
        if (is_byte)
            load_val = {{24{is_signed & rd_word[7]}}, rd_word[7:0]};
        else if (is_half)
            load_val = {{16{is_signed & rd_word[15]}}, rd_word[15:0]};
        else
            load_val = rd_word;
        dout_d = dout_q;
        if (commit)
            dout_d = (op_we || suppress) ? 32'd0 : load_val;
    end

    // Control and request-latch registers; reset aborts any in-flight request
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wtype_q <= 3'd0;
            din_q   <= 32'd0;
            dout_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            err_q   <= commit && misalign && suppress;
            if (accept) begin
                we_q    <= dm.we;
                addr_q  <= dm.addr;
                wtype_q <= dm.wtype;
                din_q   <= dm.din;
            end
        end
    end

    // Byte array write port; contents survive reset, a held reset blocks commits
    always_ff @(posedge clk) begin
        if (commit && op_we && !suppress && clrn) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_lane[k])
                    mem_q[byte_addr[k]] <= op_din[8*k +: 8];
            end
        end
    end

    assign dm.ready = (state_q == S_RESP);
    assign dm.busy  = (state_q != S_IDLE);
    assign dm.dout  = dout_q;
`ifdef DM_ALIGN_ERR_EN
    assign dm.err   = err_q;
`endif
endmodule
